audio_out_serializer: RTL and testbench
=======================================

AUDIO_OUT_SERIALIZER -- requirements
Module: audio_out_serializer

Interface
REQ-001 Parameter AUDIO_DATA_WIDTH, default 32: sample width, equal to the width of the upstream sync FIFO words.
REQ-002 Parameter UNDERFLOW_CNT_WIDTH, default 8: width of the underflow counter.
REQ-003 clk  input  1  single block clock; all logic is synchronous to its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 clear_audio_out_memory  input  1  synchronous soft clear.
REQ-006 bit_clk_falling_edge  input  1  one-clk strobe marking a codec BCLK falling edge.
REQ-007 left_right_clk_rising_edge  input  1  one-clk strobe marking the start of the left-channel frame.
REQ-008 left_right_clk_falling_edge  input  1  one-clk strobe marking the start of the right-channel frame.
REQ-009 left_fifo_data  input  AUDIO_DATA_WIDTH  head word of the left show-ahead FIFO.
REQ-010 left_fifo_empty  input  1  left FIFO empty flag.
REQ-011 right_fifo_data  input  AUDIO_DATA_WIDTH  head word of the right show-ahead FIFO.
REQ-012 right_fifo_empty  input  1  right FIFO empty flag.
REQ-013 left_fifo_read_en  output  1  one-clk pop pulse to the left FIFO.
REQ-014 right_fifo_read_en  output  1  one-clk pop pulse to the right FIFO.
REQ-015 serial_audio_out_data  output  1  serial DAC data, MSB first.
REQ-016 underflow_count  output  UNDERFLOW_CNT_WIDTH  saturating count of underflowed frames.

Function
REQ-017 The state machine SHALL have three states: IDLE, LEFT and RIGHT.
REQ-018 Transitions:
- IDLE->LEFT on left_right_clk_rising_edge.
- LEFT->RIGHT on left_right_clk_falling_edge.
- RIGHT->LEFT on left_right_clk_rising_edge.
- All other strobes leave the state unchanged.
REQ-019 In IDLE, serial_audio_out_data SHALL be held at 0.
REQ-020 Frame start, when both FIFOs are non-empty and a left_right_clk_rising_edge occurs in any state:
- shift register <= left_fifo_data;
- right hold register <= right_fifo_data;
- left_fifo_read_en and right_fifo_read_en pulse high together for exactly one cycle, in the cycle after the strobe (registered).
REQ-021 Underflow, when either FIFO is empty at the rising strobe:
- the shift register and hold register SHALL load all zeros;
- no read_en SHALL be asserted; the block never pops one FIFO without the other;
- underflow_count SHALL increment by 1, saturating at all-ones.
REQ-022 On left_right_clk_falling_edge in LEFT, the shift register SHALL load the hold register; no FIFO read occurs.
REQ-023 On each bit_clk_falling_edge outside IDLE:
- serial_audio_out_data <= shift register MSB;
- the shift register shifts left by one with zero fill.
REQ-024 If a load (REQ-020, REQ-021 or REQ-022) and bit_clk_falling_edge coincide, the load SHALL win and no shift occurs, which gives the one-BCLK I2S data delay.
REQ-025 After AUDIO_DATA_WIDTH shifts, the output SHALL stay 0 until the next load.
REQ-026 Simultaneous left_right_clk rising and falling strobes are illegal; the rising strobe SHALL take priority.
REQ-027 clear_audio_out_memory SHALL, in the next cycle:
- force IDLE;
- zero the shift register, hold register, serial output and underflow_count;
- suppress read_en.
REQ-028 clear_audio_out_memory SHALL override every other input in the same cycle.

Reset
REQ-029 While reset is low, the block SHALL asynchronously force state IDLE, all registers 0, both read_en outputs 0, serial_audio_out_data 0 and underflow_count 0.
REQ-030 After reset deassertion, the first output frame SHALL begin only at a left_right_clk_rising_edge; a reset mid-frame discards that frame.

Structure
REQ-031 A shared package audio_pkg SHALL hold the state enumeration type and the default AUDIO_DATA_WIDTH constant.
REQ-032 One sub-module, audio_bit_shifter, SHALL provide the parallel-load / shift-left / MSB-out register with load priority.
REQ-033 The FSM, read-pulse and underflow logic SHALL live in the top module.

Verification
REQ-034 Load and shift, AUDIO_DATA_WIDTH=32:
- stimulus: left=0xA5A50001, right=0x0000FFFF, both non-empty; lr rise; 32 BCLK falls; lr fall; 32 BCLK falls;
- response: serial stream 0xA5A50001 MSB-first then 0x0000FFFF; exactly one read_en pulse per FIFO, one cycle after lr rise.
REQ-035 Underflow:
- stimulus: right_fifo_empty=1 at lr rise;
- response: 64 zero bits; no read_en; underflow_count=1.
REQ-036 Saturation: 300 consecutive underflowed frames -> underflow_count=255.
REQ-037 Coincident strobes: lr rise and BCLK fall in the same cycle -> word loaded, first MSB appears on the following BCLK fall.
REQ-038 Clear mid-frame: assert clear after 10 bits of a left word -> state IDLE, output 0, count 0; the next lr rise restarts cleanly.
REQ-039 Reset mid-frame: pull reset low asynchronously between clock edges -> all outputs 0 immediately; no read_en until the next lr rise.

Source files
------------

// File: rtl/audio_pkg.sv
// -----------------------------------------------------------------------------
// audio_pkg
// Shared definitions for the audio output serializer slice.
//   AUDIO_DATA_WIDTH_DEFAULT : default sample / FIFO word width
//   audio_state_t            : frame state of the serializer
//                              (IDLE, LEFT channel, RIGHT channel)
// -----------------------------------------------------------------------------
package audio_pkg;

    localparam int AUDIO_DATA_WIDTH_DEFAULT = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LEFT  = 2'd1,
        ST_RIGHT = 2'd2
    } audio_state_t;

endpackage

// File: rtl/audio_out_serializer_if.sv
// -----------------------------------------------------------------------------
// audio_out_serializer_if
// Bundle of the two show-ahead FIFO read ports feeding the serializer.
//   left_fifo_data / right_fifo_data   : head word of each FIFO
//   left_fifo_empty / right_fifo_empty : FIFO empty flags
//   left_fifo_read_en / right_fifo_read_en : one-clk pop pulses
//
// Handshake: the FIFO presents its head word with empty=0 (the "valid"
// side, empty acting as not-valid); a pop happens on any clk where read_en=1
// and must only be issued while empty=0. The serializer always pops both
// FIFOs together or neither, so the channels can never slip against each
// other.
//
// Modports:
//   master : FIFO side (drives data/empty, receives read_en)
//   slave  : serializer side (receives data/empty, drives read_en)
// -----------------------------------------------------------------------------
interface audio_out_serializer_if #(
    parameter int AUDIO_DATA_WIDTH = audio_pkg::AUDIO_DATA_WIDTH_DEFAULT
);

    logic [AUDIO_DATA_WIDTH-1:0] left_fifo_data;
    logic                        left_fifo_empty;
    logic                        left_fifo_read_en;
    logic [AUDIO_DATA_WIDTH-1:0] right_fifo_data;
    logic                        right_fifo_empty;
    logic                        right_fifo_read_en;

    modport master (
        output left_fifo_data,
        output left_fifo_empty,
        input  left_fifo_read_en,
        output right_fifo_data,
        output right_fifo_empty,
        input  right_fifo_read_en
    );

    modport slave (
        input  left_fifo_data,
        input  left_fifo_empty,
        output left_fifo_read_en,
        input  right_fifo_data,
        input  right_fifo_empty,
        output right_fifo_read_en
    );

endinterface

// File: rtl/audio_bit_shifter.sv
// -----------------------------------------------------------------------------
// audio_bit_shifter
// Parallel-load, shift-left, MSB-out register with a registered serial output.
//   clk, reset   : clock, asynchronous active-low reset
//   clear        : synchronous clear of register and serial output
//   load         : parallel load of load_data (has priority over shift)
//   load_data    : word to load
//   shift        : shift one bit out, MSB first, zero fill
//   serial_out   : registered serial bit
// A load does not touch serial_out, so the bit on the line before the load
// keeps being driven until the next shift (the one-BCLK I2S delay).
// -----------------------------------------------------------------------------
module audio_bit_shifter #(
    parameter int WIDTH = audio_pkg::AUDIO_DATA_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift,
    output logic             serial_out
);

    logic [WIDTH-1:0] shift_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift_reg  <= '0;
            serial_out <= 1'b0;
        end else if (clear) begin
            shift_reg  <= '0;
            serial_out <= 1'b0;
        end else if (load) begin
            shift_reg  <= load_data;
        end else if (shift) begin
            serial_out <= shift_reg[WIDTH-1];
            shift_reg  <= {shift_reg[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/audio_out_serializer.sv
// -----------------------------------------------------------------------------
// audio_out_serializer
// I2S-style DAC data serializer fed by a left and a right show-ahead FIFO.
//   clk                          : block clock (rising edge)
//   reset                        : asynchronous active-low reset
//   clear_audio_out_memory       : synchronous soft clear, overrides all
//   bit_clk_falling_edge         : one-clk strobe, codec BCLK falling edge
//   left_right_clk_rising_edge   : one-clk strobe, left frame start
//   left_right_clk_falling_edge  : one-clk strobe, right frame start
//   fifo                         : FIFO read ports (slave modport)
//   serial_audio_out_data        : serial data, MSB first
//   underflow_count              : saturating count of underflowed frames
//   state_dbg                    : current frame state
//
// At a left/right rising strobe the left word goes straight into the shifter
// and the right word is parked in a hold register, and both FIFOs are popped
// in the next cycle. If either FIFO is empty the whole frame is played as
// silence and counted as an underflow instead.
// -----------------------------------------------------------------------------
module audio_out_serializer
    import audio_pkg::*;
#(
    parameter int AUDIO_DATA_WIDTH    = AUDIO_DATA_WIDTH_DEFAULT,
    parameter int UNDERFLOW_CNT_WIDTH = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           clear_audio_out_memory,
    input  logic                           bit_clk_falling_edge,
    input  logic                           left_right_clk_rising_edge,
    input  logic                           left_right_clk_falling_edge,
    audio_out_serializer_if.slave          fifo,
    output logic                           serial_audio_out_data,
    output logic [UNDERFLOW_CNT_WIDTH-1:0] underflow_count,
    output audio_state_t                   state_dbg
);

    audio_state_t                state;
    audio_state_t                next_state;
    logic [AUDIO_DATA_WIDTH-1:0] hold_reg;
    logic [AUDIO_DATA_WIDTH-1:0] load_data;
    logic                        load;
    logic                        shift;
    logic                        start_frame;
    logic                        frame_ok;
    logic                        read_en_q;

    assign frame_ok  = !fifo.left_fifo_empty && !fifo.right_fifo_empty;
    assign state_dbg = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Priority: clear > rising strobe (also wins over an illegal coincident
    // falling strobe) > falling strobe in LEFT > BCLK shift.
    always_comb begin
        next_state  = state;
        load        = 1'b0;
        load_data   = '0;
        shift       = 1'b0;
        start_frame = 1'b0;
        if (clear_audio_out_memory) begin
            next_state = ST_IDLE;
        end else if (left_right_clk_rising_edge) begin
            next_state  = ST_LEFT;
            load        = 1'b1;
            load_data   = frame_ok ? fifo.left_fifo_data : '0;
            start_frame = 1'b1;
        end else if (left_right_clk_falling_edge && state == ST_LEFT) begin
            next_state = ST_RIGHT;
            load       = 1'b1;
            load_data  = hold_reg;
        end else if (bit_clk_falling_edge && state != ST_IDLE) begin
            shift = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_reg        <= '0;
            read_en_q       <= 1'b0;
            underflow_count <= '0;
        end else if (clear_audio_out_memory) begin
            hold_reg        <= '0;
            read_en_q       <= 1'b0;
            underflow_count <= '0;
        end else begin
            read_en_q <= start_frame && frame_ok;
            if (start_frame) begin
                hold_reg <= frame_ok ? fifo.right_fifo_data : '0;
                if (!frame_ok && underflow_count != '1) begin
                    underflow_count <= underflow_count + UNDERFLOW_CNT_WIDTH'(1);
                end
            end
        end
    end

    // One shared pulse keeps the two FIFOs in lock-step.
    assign fifo.left_fifo_read_en  = read_en_q;
    assign fifo.right_fifo_read_en = read_en_q;

    audio_bit_shifter #(
        .WIDTH(AUDIO_DATA_WIDTH)
    ) u_bit_shifter (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear_audio_out_memory),
        .load       (load),
        .load_data  (load_data),
        .shift      (shift),
        .serial_out (serial_audio_out_data)
    );

endmodule

// File: tb/tb_audio_out_serializer.sv
module tb_audio_out_serializer;
    import audio_pkg::*;

    localparam int W      = 32;
    localparam int CW     = 8;
    localparam int CNTMAX = (1 << CW) - 1;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic          clear_mem;
    logic          bclk_fall;
    logic          lr_rise;
    logic          lr_fall;
    logic          serial;
    logic [CW-1:0] ucount;
    audio_state_t  state_dbg;

    audio_out_serializer_if #(.AUDIO_DATA_WIDTH(W)) fifo_if ();

    audio_out_serializer #(
        .AUDIO_DATA_WIDTH    (W),
        .UNDERFLOW_CNT_WIDTH (CW)
    ) dut (
        .clk                         (clk),
        .reset                       (reset),
        .clear_audio_out_memory      (clear_mem),
        .bit_clk_falling_edge        (bclk_fall),
        .left_right_clk_rising_edge  (lr_rise),
        .left_right_clk_falling_edge (lr_fall),
        .fifo                        (fifo_if.slave),
        .serial_audio_out_data       (serial),
        .underflow_count             (ucount),
        .state_dbg                   (state_dbg)
    );

    int checks   = 0;
    int failures = 0;
    int rd_l_cnt = 0;
    int rd_r_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Frame-level view: a bit queue holds what is still to be played,
    // the parked right word waits for the channel switch.
    bit          m_idle;
    bit          m_left;
    logic [W-1:0] m_hold;
    bit          m_bits[$];
    logic        m_serial;
    logic        m_rd;
    int          m_count;

    task automatic model_reset();
        m_idle   = 1'b1;
        m_left   = 1'b0;
        m_hold   = '0;
        m_bits.delete();
        m_serial = 1'b0;
        m_rd     = 1'b0;
        m_count  = 0;
    endtask

    task automatic model_queue_word(input logic [W-1:0] w);
        m_bits.delete();
        for (int i = W - 1; i >= 0; i--) m_bits.push_back(w[i]);
    endtask

    task automatic model_step(input bit clr, input bit bc, input bit ri, input bit fa,
                              input bit le, input bit re,
                              input logic [W-1:0] ld, input logic [W-1:0] rdat);
        bit ok;
        if (clr) begin
            model_reset();
        end else begin
            ok   = !le && !re;
            m_rd = ri && ok;
            if (ri) begin
                m_idle = 1'b0;
                m_left = 1'b1;
                model_queue_word(ok ? ld : '0);
                m_hold = ok ? rdat : '0;
                if (!ok && m_count < CNTMAX) m_count++;
            end else if (fa && !m_idle && m_left) begin
                model_queue_word(m_hold);
                m_left = 1'b0;
            end else if (bc && !m_idle) begin
                m_serial = (m_bits.size() > 0) ? m_bits.pop_front() : 1'b0;
            end
        end
    endtask

    function automatic audio_state_t model_state();
        if (m_idle) return ST_IDLE;
        return m_left ? ST_LEFT : ST_RIGHT;
    endfunction

    // ---------------- driver ----------------
    // Drive one clk worth of inputs, step to 1 ns after the edge, compare.
    task automatic cycle(input bit clr, input bit bc, input bit ri, input bit fa,
                         input bit le, input bit re,
                         input logic [W-1:0] ld, input logic [W-1:0] rdat);
        clear_mem                = clr;
        bclk_fall                = bc;
        lr_rise                  = ri;
        lr_fall                  = fa;
        fifo_if.left_fifo_empty  = le;
        fifo_if.right_fifo_empty = re;
        fifo_if.left_fifo_data   = ld;
        fifo_if.right_fifo_data  = rdat;
        @(posedge clk);
        #1;
        model_step(clr, bc, ri, fa, le, re, ld, rdat);
        if (fifo_if.left_fifo_read_en)  rd_l_cnt++;
        if (fifo_if.right_fifo_read_en) rd_r_cnt++;
        check("serial",   64'(serial), 64'(m_serial));
        check("rd_left",  64'(fifo_if.left_fifo_read_en), 64'(m_rd));
        check("rd_right", 64'(fifo_if.right_fifo_read_en), 64'(m_rd));
        check("count",    64'(ucount), 64'(m_count));
        check("state",    64'(state_dbg), 64'(model_state()));
    endtask

    task automatic idle_cyc(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 1, 1, '0, '0);
    endtask

    task automatic collect(input int n, output logic [W-1:0] w);
        w = '0;
        for (int i = 0; i < n; i++) begin
            cycle(0, 1, 0, 0, 1, 1, '0, '0);
            w = {w[W-2:0], serial};
        end
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        bit           clr, bc, ri, fa, le, re;
        logic [W-1:0] ld, rdat;
        logic         exp_ser;
        logic         exp_rd;
        audio_state_t exp_st;
        int           exp_cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit clr, bit bc, bit ri, bit fa, bit le, bit re,
                                logic [W-1:0] ld, logic [W-1:0] rdat,
                                logic es, logic er, audio_state_t est, int ec);
        vec_t v;
        v.clr = clr; v.bc = bc; v.ri = ri; v.fa = fa; v.le = le; v.re = re;
        v.ld = ld; v.rdat = rdat;
        v.exp_ser = es; v.exp_rd = er; v.exp_st = est; v.exp_cnt = ec;
        return v;
    endfunction

    // ---------------- watchdog ----------------
    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "time limit");
    end

    // ---------------- main ----------------
    initial begin
        logic [W-1:0] w;
        int           bcnt;
        bit           c, b, r, f, le, re;

        clear_mem = 0; bclk_fall = 0; lr_rise = 0; lr_fall = 0;
        fifo_if.left_fifo_empty = 1; fifo_if.right_fifo_empty = 1;
        fifo_if.left_fifo_data = '0; fifo_if.right_fifo_data = '0;
        model_reset();

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_serial", 64'(serial), 64'd0);
        check("rst_rd",     64'(fifo_if.left_fifo_read_en | fifo_if.right_fifo_read_en), 64'd0);
        check("rst_count",  64'(ucount), 64'd0);
        check("rst_state",  64'(state_dbg), 64'(ST_IDLE));
        reset = 1'b1;

        // directed table
        vecs.push_back(mk(0,1,0,0,1,1, 32'h0,        32'h0,        0,0,ST_IDLE, 0));
        vecs.push_back(mk(0,0,0,1,0,0, 32'h0,        32'h0,        0,0,ST_IDLE, 0));
        vecs.push_back(mk(0,0,1,0,0,0, 32'h80000001, 32'h40000000, 0,1,ST_LEFT, 0));
        vecs.push_back(mk(0,1,0,0,1,1, 32'h0,        32'h0,        1,0,ST_LEFT, 0));
        vecs.push_back(mk(0,1,0,0,1,1, 32'h0,        32'h0,        0,0,ST_LEFT, 0));
        vecs.push_back(mk(0,0,0,0,1,1, 32'h0,        32'h0,        0,0,ST_LEFT, 0));
        vecs.push_back(mk(0,0,0,1,1,1, 32'h0,        32'h0,        0,0,ST_RIGHT,0));
        vecs.push_back(mk(0,1,0,0,1,1, 32'h0,        32'h0,        0,0,ST_RIGHT,0));
        vecs.push_back(mk(0,1,0,0,1,1, 32'h0,        32'h0,        1,0,ST_RIGHT,0));
        vecs.push_back(mk(0,1,0,0,1,1, 32'h0,        32'h0,        0,0,ST_RIGHT,0));
        vecs.push_back(mk(0,0,1,0,0,1, 32'hFFFFFFFF, 32'h0,        0,0,ST_LEFT, 1));
        vecs.push_back(mk(0,1,0,0,1,1, 32'h0,        32'h0,        0,0,ST_LEFT, 1));
        vecs.push_back(mk(0,0,1,1,0,0, 32'hFFFFFFFF, 32'h7FFFFFFF, 0,1,ST_LEFT, 1));
        vecs.push_back(mk(0,1,0,0,1,1, 32'h0,        32'h0,        1,0,ST_LEFT, 1));
        vecs.push_back(mk(0,1,0,1,1,1, 32'h0,        32'h0,        1,0,ST_RIGHT,1));
        vecs.push_back(mk(0,1,0,0,1,1, 32'h0,        32'h0,        0,0,ST_RIGHT,1));
        vecs.push_back(mk(0,1,0,0,1,1, 32'h0,        32'h0,        1,0,ST_RIGHT,1));
        vecs.push_back(mk(1,1,1,0,0,0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0,0,ST_IDLE, 0));
        vecs.push_back(mk(0,1,0,0,1,1, 32'h0,        32'h0,        0,0,ST_IDLE, 0));
        vecs.push_back(mk(0,0,0,1,0,0, 32'h0,        32'h0,        0,0,ST_IDLE, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            cycle(vecs[i].clr, vecs[i].bc, vecs[i].ri, vecs[i].fa,
                  vecs[i].le, vecs[i].re, vecs[i].ld, vecs[i].rdat);
            check($sformatf("vec%0d_serial", i), 64'(serial), 64'(vecs[i].exp_ser));
            check($sformatf("vec%0d_rd", i), 64'(fifo_if.left_fifo_read_en), 64'(vecs[i].exp_rd));
            check($sformatf("vec%0d_state", i), 64'(state_dbg), 64'(vecs[i].exp_st));
            check($sformatf("vec%0d_count", i), 64'(ucount), 64'(vecs[i].exp_cnt));
        end

        // load and shift: two full words, one pop per FIFO
        rd_l_cnt = 0; rd_r_cnt = 0;
        cycle(0, 0, 1, 0, 0, 0, 32'hA5A50001, 32'h0000FFFF);
        check("ls_rd_after_rise", 64'(fifo_if.left_fifo_read_en), 64'd1);
        collect(W, w);
        check("ls_left_word", 64'(w), 64'hA5A50001);
        cycle(0, 0, 0, 1, 1, 1, '0, '0);
        collect(W, w);
        check("ls_right_word", 64'(w), 64'h0000FFFF);
        check("ls_rd_l_pulses", 64'(rd_l_cnt), 64'd1);
        check("ls_rd_r_pulses", 64'(rd_r_cnt), 64'd1);

        // underflow: right empty gives a silent frame, no pops
        cycle(1, 0, 0, 0, 1, 1, '0, '0);
        rd_l_cnt = 0; rd_r_cnt = 0;
        cycle(0, 0, 1, 0, 0, 1, 32'hFFFFFFFF, 32'hFFFFFFFF);
        collect(W, w);
        check("uf_left_word", 64'(w), 64'd0);
        cycle(0, 0, 0, 1, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF);
        collect(W, w);
        check("uf_right_word", 64'(w), 64'd0);
        check("uf_no_pops", 64'(rd_l_cnt + rd_r_cnt), 64'd0);
        check("uf_count", 64'(ucount), 64'd1);

        // saturation
        cycle(1, 0, 0, 0, 1, 1, '0, '0);
        for (int i = 0; i < 300; i++) begin
            cycle(0, 0, 1, 0, (i % 2 == 0), 1'b1, 32'h12345678, 32'h9ABCDEF0);
            cycle(0, 1, 0, 0, 1, 1, '0, '0);
            if (i == 0) check("sat_first", 64'(ucount), 64'd1);
        end
        check("sat_final", 64'(ucount), 64'(CNTMAX));

        // coincident lr rise and BCLK fall: MSB shows on the following fall
        cycle(1, 0, 0, 0, 1, 1, '0, '0);
        cycle(0, 1, 1, 0, 0, 0, 32'h80000000, 32'h0);
        check("co_no_shift", 64'(serial), 64'd0);
        cycle(0, 1, 0, 0, 1, 1, '0, '0);
        check("co_msb", 64'(serial), 64'd1);
        cycle(0, 1, 0, 0, 1, 1, '0, '0);
        check("co_bit2", 64'(serial), 64'd0);

        // clear mid-frame
        cycle(0, 0, 1, 0, 1, 0, '0, '0);
        cycle(0, 0, 1, 0, 0, 0, 32'hFFFFFFFF, 32'h0);
        for (int i = 0; i < 10; i++) cycle(0, 1, 0, 0, 1, 1, '0, '0);
        check("cl_before_serial", 64'(serial), 64'd1);
        cycle(1, 1, 0, 0, 0, 0, '0, '0);
        check("cl_state", 64'(state_dbg), 64'(ST_IDLE));
        check("cl_serial", 64'(serial), 64'd0);
        check("cl_count", 64'(ucount), 64'd0);
        cycle(0, 1, 0, 1, 1, 1, '0, '0);
        cycle(0, 0, 1, 0, 0, 0, 32'hC0000000, 32'h0);
        check("cl_restart_rd", 64'(fifo_if.left_fifo_read_en), 64'd1);
        collect(2, w);
        check("cl_restart_bits", 64'(w[1:0]), 64'd3);

        // asynchronous reset mid-frame, while a pop pulse is high
        cycle(0, 0, 1, 0, 1, 0, '0, '0);
        cycle(0, 0, 1, 0, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF);
        for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0, 1, 1, '0, '0);
        cycle(0, 0, 1, 0, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF);
        check("rs_pre_rd", 64'(fifo_if.left_fifo_read_en), 64'd1);
        bclk_fall = 0; lr_rise = 0; lr_fall = 0;
        #3;
        reset = 1'b0;
        #1;
        model_reset();
        check("rs_serial", 64'(serial), 64'd0);
        check("rs_rd", 64'(fifo_if.left_fifo_read_en | fifo_if.right_fifo_read_en), 64'd0);
        check("rs_count", 64'(ucount), 64'd0);
        check("rs_state", 64'(state_dbg), 64'(ST_IDLE));
        @(posedge clk);
        #1;
        reset = 1'b1;
        rd_l_cnt = 0;
        for (int i = 0; i < 6; i++) cycle(0, 1, 0, (i == 2), 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF);
        check("rs_no_pop", 64'(rd_l_cnt), 64'd0);
        cycle(0, 0, 1, 0, 0, 0, 32'h80000000, 32'h0);
        check("rs_first_pop", 64'(fifo_if.left_fifo_read_en), 64'd1);
        idle_cyc(2);

        // randomized I2S-like traffic with sporadic disturbances
        bcnt = 0;
        for (int n = 0; n < 6000; n++) begin
            b = (n % 2 == 0);
            r = 0;
            f = 0;
            if (b) begin
                r = (bcnt % 64 == 0);
                f = (bcnt % 64 == 32);
                bcnt++;
            end
            if ($urandom_range(0, 199) == 0) r = 1;
            if ($urandom_range(0, 199) == 0) f = 1;
            c  = ($urandom_range(0, 1499) == 0);
            le = ($urandom_range(0, 7) == 0);
            re = ($urandom_range(0, 7) == 0);
            cycle(c, b, r, f, le, re, W'($urandom), W'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
